axi_ax_fifo_buffer: RTL and testbench
=====================================

# axi_ax_fifo_buffer

Parametrised, depth-configurable address-channel buffer for the AXI-to-APB bridge. One block serves either AW or AR, selected by parameter. It stores up to DEPTH requests in a circular FIFO, with an optional fall-through path. It also reports occupancy and total outstanding data beats, so the W/R-side logic can pre-allocate without probing the channel.

## Interface
- ID_WIDTH, 4: AxID width, ≥1
- ADDR_WIDTH, 32: AxADDR width, ≥12
- USER_WIDTH, 1: AxUSER width, ≥1
- DEPTH, 4: entries, ≥1, any integer (not restricted to powers of two)
- FALL_THROUGH, 0: 1 = empty buffer passes a request combinationally in the same cycle; 0 = minimum one-cycle latency
- IS_WRITE, 1: 1 = AW channel (atop field carried), 0 = AR channel (atop forced 0 on output)

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous, active-low reset
- test_en_i  in  1  test mode; no functional effect, tied into clock-gating hooks only
- slave_valid_i / slave_ready_o  in / out  1  upstream handshake
- slave_addr_i  in  ADDR_WIDTH;  slave_prot_i 3;  slave_region_i 4;  slave_len_i 8;  slave_size_i 3;  slave_burst_i 2;  slave_lock_i 1;  slave_cache_i 4;  slave_qos_i 4;  slave_atop_i 6;  slave_id_i ID_WIDTH;  slave_user_i USER_WIDTH — request fields
- master_valid_o / master_ready_i  out / in  1  downstream handshake
- master_* outputs  out  same widths  mirror of every slave_* field
- usage_o  out  $clog2(DEPTH+1)  stored entries
- beats_o  out  $clog2(DEPTH*256+1)  sum of (len+1) over stored entries

## Operation
- Packed entry width: AX_FIXED_W (35) + ADDR_WIDTH + ID_WIDTH + USER_WIDTH.
  - AX_FIXED_W covers cache, prot, lock, burst, size, len, qos, region and atop.
- Push: slave_valid_i && slave_ready_o. Pop: master_valid_o && master_ready_i.
- slave_ready_o = (usage != DEPTH). It depends only on state and never on master_ready_i, so there is no combinational ready path.
- master_valid_o = (usage != 0), or, when FALL_THROUGH=1 and usage==0, slave_valid_i.
- When fall-through is active, master_* = slave_*. Otherwise master_* = entry at the read pointer.
- Write and read pointers wrap from DEPTH-1 to 0.
- Counter updates:
  - usage: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
  - beats: adds slave_len_i+1 on push and subtracts head len+1 on pop, both in the same cycle if both occur.
- Fall-through push and pop in the same cycle: nothing is stored, and both counters stay at 0.
- When IS_WRITE=0, slave_atop_i is ignored and not stored, and master_atop_o = 0.
- Fields are not interpreted; illegal burst/len combinations pass through unchanged.

## Timing
- Reset values (asynchronous, immediate):
  - pointers = 0, usage_o = 0, beats_o = 0
  - master_valid_o = 0 (when FALL_THROUGH=1, it follows slave_valid_i)
  - slave_ready_o = 1
  - storage = 0, so master_* = 0 when not falling through
- Latency:
  - FALL_THROUGH=0: a request pushed at edge N is visible on master from N+1.
  - FALL_THROUGH=1, empty: 0 cycles.
- Once asserted, master_valid_o stays high with stable data until the pop. Upstream is expected to obey the same AXI rule, so fall-through outputs are stable too.
- Full: slave_ready_o drops in the cycle after the DEPTH-th push. A pop while full does not raise slave_ready_o until the next cycle.
- Reset asserted mid-burst: all queued requests are discarded; no partial state survives.

## Structure
- axi_buf_pkg holds:
  - the AX_FIXED_W constant
  - the per-field width localparams
  - a burst-type enum (FIXED/INCR/WRAP)
  - a function `ax_pack`/`ax_unpack` ordering: cache, prot, lock, burst, size, len, qos, region, atop, addr, user, id, MSB first
- The storage array and pointers go in one sub-module, axi_fifo_core, parametrised on DATA_WIDTH, DEPTH and FALL_THROUGH, with valid/ready on both sides plus usage.
- The top level handles packing, atop gating and the beats accumulator.

## Test plan
- Reset then idle, DEPTH=4 → slave_ready_o=1, master_valid_o=0, usage_o=0, beats_o=0.
- FALL_THROUGH=0, push len=3 addr=0x1000 with master_ready_i=0 → next cycle master_valid_o=1, master_addr_o=0x1000, usage_o=1, beats_o=4.
- Push 4 requests, master_ready_i=0 → slave_ready_o=0 after the 4th, usage_o=4. Then one pop → ready=1 the following cycle, data returned in order.
- Simultaneous push (len=7) and pop (head len=0) with usage=2 → usage_o stays 2, beats_o grows by 7.
- FALL_THROUGH=1, empty, slave_valid_i=1, master_ready_i=1 → master_valid_o=1 in the same cycle, fields equal to inputs, usage_o stays 0.
- Fill DEPTH=3 and pop across 10 entries to exercise pointer wrap. Assert rst_ni mid-stream → master_valid_o=0 and usage_o=0 immediately. IS_WRITE=0 with slave_atop_i=0x2A → master_atop_o=0.

Source files
------------

// File: rtl/axi_buf_pkg.sv
// Shared widths, field types and packing helpers for the AXI address-channel buffer.
package axi_buf_pkg;

    localparam int unsigned CACHE_W  = 4;
    localparam int unsigned PROT_W   = 3;
    localparam int unsigned LOCK_W   = 1;
    localparam int unsigned BURST_W  = 2;
    localparam int unsigned SIZE_W   = 3;
    localparam int unsigned LEN_W    = 8;
    localparam int unsigned QOS_W    = 4;
    localparam int unsigned REGION_W = 4;
    localparam int unsigned ATOP_W   = 6;

    // Width of every request field except addr, user and id.
    localparam int unsigned AX_FIXED_W = CACHE_W + PROT_W + LOCK_W + BURST_W + SIZE_W + LEN_W +
                                         QOS_W + REGION_W + ATOP_W;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } axi_burst_e;

    // Burst is kept as raw bits so reserved encodings pass through untouched.
    typedef struct packed {
        logic [CACHE_W-1:0]  cache;
        logic [PROT_W-1:0]   prot;
        logic [LOCK_W-1:0]   lock;
        logic [BURST_W-1:0]  burst;
        logic [SIZE_W-1:0]   size;
        logic [LEN_W-1:0]    len;
        logic [QOS_W-1:0]    qos;
        logic [REGION_W-1:0] region;
        logic [ATOP_W-1:0]   atop;
    } ax_fixed_t;

    // Fixed fields, MSB first: cache, prot, lock, burst, size, len, qos, region, atop.
    // addr, user and id follow below these in the stored entry.
    function automatic logic [AX_FIXED_W-1:0] ax_pack(
        input logic [CACHE_W-1:0]  cache,
        input logic [PROT_W-1:0]   prot,
        input logic [LOCK_W-1:0]   lock,
        input logic [BURST_W-1:0]  burst,
        input logic [SIZE_W-1:0]   size,
        input logic [LEN_W-1:0]    len,
        input logic [QOS_W-1:0]    qos,
        input logic [REGION_W-1:0] region,
        input logic [ATOP_W-1:0]   atop
    );
        return {cache, prot, lock, burst, size, len, qos, region, atop};
    endfunction

    function automatic ax_fixed_t ax_unpack(input logic [AX_FIXED_W-1:0] vec);
        return ax_fixed_t'(vec);
    endfunction

endpackage

// File: rtl/axi_fifo_core.sv
// Circular FIFO with optional fall-through. Ready depends only on state, never on out_ready_i.
module axi_fifo_core #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned DEPTH        = 4,
    parameter bit          FALL_THROUGH = 1'b0,
    localparam int unsigned USAGE_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [USAGE_W-1:0]    usage_o,
    output logic                  wr_en_o,
    output logic                  rd_en_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [USAGE_W-1:0]    usage_q, usage_d;
    logic                  empty, full, ft_active, push, pop;

    assign empty     = (usage_q == '0);
    assign full      = (usage_q == USAGE_W'(DEPTH));
    assign ft_active = FALL_THROUGH && empty;

    assign in_ready_o  = !full;
    assign out_valid_o = !empty || (ft_active && in_valid_i);
    assign out_data_o  = ft_active ? in_data_i : mem_q[rd_ptr_q];
    assign usage_o     = usage_q;

    assign push = in_valid_i && in_ready_o;
    assign pop  = out_valid_o && out_ready_i;

    // A fall-through pop consumes the incoming request directly, so nothing is stored.
    assign wr_en_o = push && !(ft_active && pop);
    assign rd_en_o = pop && !ft_active;

    // Next-state for pointers and occupancy; pointers wrap at DEPTH-1.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        usage_d  = usage_q;
        if (wr_en_o) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (rd_en_o) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        if (wr_en_o && !rd_en_o) begin
            usage_d = usage_q + USAGE_W'(1);
        end else if (rd_en_o && !wr_en_o) begin
            usage_d = usage_q - USAGE_W'(1);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usage_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            usage_q  <= usage_d;
        end
    end

    // Storage array, cleared on reset so idle outputs read as zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_o) begin
            mem_q[wr_ptr_q] <= in_data_i;
        end
    end

endmodule

// File: rtl/axi_ax_fifo_buffer.sv
// AW/AR request buffer: packs fields into the FIFO core, gates atop for AR, tracks beats.
module axi_ax_fifo_buffer
    import axi_buf_pkg::*;
#(
    parameter int unsigned ID_WIDTH     = 4,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned USER_WIDTH   = 1,
    parameter int unsigned DEPTH        = 4,
    parameter bit          FALL_THROUGH = 1'b0,
    parameter bit          IS_WRITE     = 1'b1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           test_en_i,
    input  logic                           slave_valid_i,
    output logic                           slave_ready_o,
    input  logic [ADDR_WIDTH-1:0]          slave_addr_i,
    input  logic [2:0]                     slave_prot_i,
    input  logic [3:0]                     slave_region_i,
    input  logic [7:0]                     slave_len_i,
    input  logic [2:0]                     slave_size_i,
    input  logic [1:0]                     slave_burst_i,
    input  logic                           slave_lock_i,
    input  logic [3:0]                     slave_cache_i,
    input  logic [3:0]                     slave_qos_i,
    input  logic [5:0]                     slave_atop_i,
    input  logic [ID_WIDTH-1:0]            slave_id_i,
    input  logic [USER_WIDTH-1:0]          slave_user_i,
    output logic                           master_valid_o,
    input  logic                           master_ready_i,
    output logic [ADDR_WIDTH-1:0]          master_addr_o,
    output logic [2:0]                     master_prot_o,
    output logic [3:0]                     master_region_o,
    output logic [7:0]                     master_len_o,
    output logic [2:0]                     master_size_o,
    output logic [1:0]                     master_burst_o,
    output logic                           master_lock_o,
    output logic [3:0]                     master_cache_o,
    output logic [3:0]                     master_qos_o,
    output logic [5:0]                     master_atop_o,
    output logic [ID_WIDTH-1:0]            master_id_o,
    output logic [USER_WIDTH-1:0]          master_user_o,
    output logic [$clog2(DEPTH+1)-1:0]     usage_o,
    output logic [$clog2(DEPTH*256+1)-1:0] beats_o
);

    localparam int unsigned DATA_WIDTH = AX_FIXED_W + ADDR_WIDTH + ID_WIDTH + USER_WIDTH;
    localparam int unsigned USAGE_W    = $clog2(DEPTH + 1);
    localparam int unsigned BEATS_W    = $clog2(DEPTH * 256 + 1);

    // Test mode only reaches clock-gating hooks; no functional use here.
    logic unused_test_en;
    assign unused_test_en = test_en_i;

    logic [ATOP_W-1:0]     atop_in;
    logic [DATA_WIDTH-1:0] in_data, out_data;
    ax_fixed_t             out_fixed;
    logic                  wr_en, rd_en;
    logic [USAGE_W-1:0]    usage;
    logic [BEATS_W-1:0]    beats_q, beats_d;

    // AR buffers never carry atop.
    assign atop_in = IS_WRITE ? slave_atop_i : '0;

    assign in_data = {ax_pack(slave_cache_i, slave_prot_i, slave_lock_i, slave_burst_i,
                              slave_size_i, slave_len_i, slave_qos_i, slave_region_i, atop_in),
                      slave_addr_i, slave_user_i, slave_id_i};

    axi_fifo_core #(
        .DATA_WIDTH   (DATA_WIDTH),
        .DEPTH        (DEPTH),
        .FALL_THROUGH (FALL_THROUGH)
    ) u_core (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (slave_valid_i),
        .in_ready_o  (slave_ready_o),
        .in_data_i   (in_data),
        .out_valid_o (master_valid_o),
        .out_ready_i (master_ready_i),
        .out_data_o  (out_data),
        .usage_o     (usage),
        .wr_en_o     (wr_en),
        .rd_en_o     (rd_en)
    );

    assign out_fixed = ax_unpack(out_data[DATA_WIDTH-1 -: AX_FIXED_W]);

    assign master_cache_o  = out_fixed.cache;
    assign master_prot_o   = out_fixed.prot;
    assign master_lock_o   = out_fixed.lock;
    assign master_burst_o  = out_fixed.burst;
    assign master_size_o   = out_fixed.size;
    assign master_len_o    = out_fixed.len;
    assign master_qos_o    = out_fixed.qos;
    assign master_region_o = out_fixed.region;
    assign master_atop_o   = IS_WRITE ? out_fixed.atop : '0;
    assign master_addr_o   = out_data[ID_WIDTH+USER_WIDTH +: ADDR_WIDTH];
    assign master_user_o   = out_data[ID_WIDTH +: USER_WIDTH];
    assign master_id_o     = out_data[ID_WIDTH-1:0];
    assign usage_o         = usage;
    assign beats_o         = beats_q;

    // Beat total follows what is actually stored; fall-through transfers never count.
    always_comb begin
        beats_d = beats_q;
        if (wr_en) begin
            beats_d = beats_d + BEATS_W'(slave_len_i) + BEATS_W'(1);
        end
        if (rd_en) begin
            beats_d = beats_d - BEATS_W'(out_fixed.len) - BEATS_W'(1);
        end
    end

    // Beat accumulator register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            beats_q <= '0;
        end else begin
            beats_q <= beats_d;
        end
    end

endmodule

// File: tb/tb_axi_ax_fifo_buffer.sv
// Directed bench: dut_a is DEPTH=4 registered AW, dut_b is DEPTH=3 fall-through AR.
module tb_axi_ax_fifo_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        test_en = 1'b0;

    // Request fields shared by both instances.
    logic [31:0] s_addr = '0;
    logic [2:0]  s_prot = '0;
    logic [3:0]  s_region = '0;
    logic [7:0]  s_len = '0;
    logic [2:0]  s_size = '0;
    logic [1:0]  s_burst = '0;
    logic        s_lock = 1'b0;
    logic [3:0]  s_cache = '0;
    logic [3:0]  s_qos = '0;
    logic [5:0]  s_atop = '0;
    logic [3:0]  s_id = '0;
    logic [0:0]  s_user = '0;

    logic        sv_a = 1'b0, mr_a = 1'b0, sv_b = 1'b0, mr_b = 1'b0;

    logic        a_ready, a_valid, a_lock, b_ready, b_valid, b_lock;
    logic [31:0] a_addr, b_addr;
    logic [2:0]  a_prot, a_size, b_prot, b_size;
    logic [3:0]  a_region, a_cache, a_qos, a_id, b_region, b_cache, b_qos, b_id;
    logic [7:0]  a_len, b_len;
    logic [1:0]  a_burst, b_burst;
    logic [5:0]  a_atop, b_atop;
    logic [0:0]  a_user, b_user;
    logic [2:0]  a_usage;
    logic [1:0]  b_usage;
    logic [10:0] a_beats;
    logic [9:0]  b_beats;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    axi_ax_fifo_buffer #(
        .ID_WIDTH (4), .ADDR_WIDTH (32), .USER_WIDTH (1),
        .DEPTH (4), .FALL_THROUGH (1'b0), .IS_WRITE (1'b1)
    ) dut_a (
        .clk_i (clk), .rst_ni (rst_n), .test_en_i (test_en),
        .slave_valid_i (sv_a), .slave_ready_o (a_ready),
        .slave_addr_i (s_addr), .slave_prot_i (s_prot), .slave_region_i (s_region),
        .slave_len_i (s_len), .slave_size_i (s_size), .slave_burst_i (s_burst),
        .slave_lock_i (s_lock), .slave_cache_i (s_cache), .slave_qos_i (s_qos),
        .slave_atop_i (s_atop), .slave_id_i (s_id), .slave_user_i (s_user),
        .master_valid_o (a_valid), .master_ready_i (mr_a),
        .master_addr_o (a_addr), .master_prot_o (a_prot), .master_region_o (a_region),
        .master_len_o (a_len), .master_size_o (a_size), .master_burst_o (a_burst),
        .master_lock_o (a_lock), .master_cache_o (a_cache), .master_qos_o (a_qos),
        .master_atop_o (a_atop), .master_id_o (a_id), .master_user_o (a_user),
        .usage_o (a_usage), .beats_o (a_beats)
    );

    axi_ax_fifo_buffer #(
        .ID_WIDTH (4), .ADDR_WIDTH (32), .USER_WIDTH (1),
        .DEPTH (3), .FALL_THROUGH (1'b1), .IS_WRITE (1'b0)
    ) dut_b (
        .clk_i (clk), .rst_ni (rst_n), .test_en_i (test_en),
        .slave_valid_i (sv_b), .slave_ready_o (b_ready),
        .slave_addr_i (s_addr), .slave_prot_i (s_prot), .slave_region_i (s_region),
        .slave_len_i (s_len), .slave_size_i (s_size), .slave_burst_i (s_burst),
        .slave_lock_i (s_lock), .slave_cache_i (s_cache), .slave_qos_i (s_qos),
        .slave_atop_i (s_atop), .slave_id_i (s_id), .slave_user_i (s_user),
        .master_valid_o (b_valid), .master_ready_i (mr_b),
        .master_addr_o (b_addr), .master_prot_o (b_prot), .master_region_o (b_region),
        .master_len_o (b_len), .master_size_o (b_size), .master_burst_o (b_burst),
        .master_lock_o (b_lock), .master_cache_o (b_cache), .master_qos_o (b_qos),
        .master_atop_o (b_atop), .master_id_o (b_id), .master_user_o (b_user),
        .usage_o (b_usage), .beats_o (b_beats)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [31:0] addr, input logic [7:0] len,
                           input logic [3:0] id, input logic [5:0] atop);
        s_addr   = addr;
        s_len    = len;
        s_id     = id;
        s_atop   = atop;
        s_prot   = 3'b101;
        s_region = 4'h3;
        s_size   = 3'd2;
        s_burst  = 2'b01;
        s_lock   = 1'b0;
        s_cache  = 4'hA;
        s_qos    = 4'h7;
        s_user   = 1'b1;
    endtask

    initial begin
        int          q_addr[$];
        int          q_len[$];
        int          beats_m;
        int          next_k;
        int          cur_addr;
        int          cur_len;
        logic        exp_valid, exp_ready, push, pop;

        // Reset state, held in reset.
        #3;
        check("rst_a_ready", 64'(a_ready), 64'(1));
        check("rst_a_valid", 64'(a_valid), 64'(0));
        check("rst_a_usage", 64'(a_usage), 64'(0));
        check("rst_a_beats", 64'(a_beats), 64'(0));
        check("rst_a_addr", 64'(a_addr), 64'(0));
        check("rst_b_valid", 64'(b_valid), 64'(0));
        check("rst_b_ready", 64'(b_ready), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;

        // First push on the registered instance: one cycle of latency.
        set_req(32'h1000, 8'd3, 4'd1, 6'h15);
        sv_a = 1'b1;
        #1;
        check("a_lat_valid_before", 64'(a_valid), 64'(0));
        tick();
        sv_a = 1'b0;
        #1;
        check("a_push1_valid", 64'(a_valid), 64'(1));
        check("a_push1_addr", 64'(a_addr), 64'('h1000));
        check("a_push1_usage", 64'(a_usage), 64'(1));
        check("a_push1_beats", 64'(a_beats), 64'(4));
        check("a_push1_len", 64'(a_len), 64'(3));
        check("a_push1_id", 64'(a_id), 64'(1));
        check("a_push1_atop", 64'(a_atop), 64'('h15));
        check("a_push1_cache", 64'(a_cache), 64'('hA));
        check("a_push1_prot", 64'(a_prot), 64'(5));
        check("a_push1_user", 64'(a_user), 64'(1));

        // Fill to DEPTH=4.
        set_req(32'h2000, 8'd1, 4'd2, 6'h0);
        sv_a = 1'b1;
        tick();
        set_req(32'h3000, 8'd0, 4'd3, 6'h0);
        tick();
        set_req(32'h4000, 8'd2, 4'd4, 6'h0);
        tick();
        sv_a = 1'b0;
        #1;
        check("a_full_usage", 64'(a_usage), 64'(4));
        check("a_full_ready", 64'(a_ready), 64'(0));
        check("a_full_beats", 64'(a_beats), 64'(10));

        // Pop while full: ready only rises after the edge.
        mr_a = 1'b1;
        #1;
        check("a_popfull_ready_same", 64'(a_ready), 64'(0));
        check("a_popfull_head", 64'(a_addr), 64'('h1000));
        tick();
        mr_a = 1'b0;
        #1;
        check("a_pop1_ready", 64'(a_ready), 64'(1));
        check("a_pop1_usage", 64'(a_usage), 64'(3));
        check("a_pop1_beats", 64'(a_beats), 64'(6));
        check("a_pop1_head", 64'(a_addr), 64'('h2000));
        check("a_pop1_id", 64'(a_id), 64'(2));

        mr_a = 1'b1;
        tick();
        mr_a = 1'b0;
        #1;
        check("a_pop2_usage", 64'(a_usage), 64'(2));
        check("a_pop2_beats", 64'(a_beats), 64'(4));
        check("a_pop2_head", 64'(a_addr), 64'('h3000));
        check("a_pop2_len", 64'(a_len), 64'(0));

        // Simultaneous push (len 7) and pop (head len 0).
        set_req(32'h5000, 8'd7, 4'd5, 6'h0);
        sv_a = 1'b1;
        mr_a = 1'b1;
        tick();
        sv_a = 1'b0;
        mr_a = 1'b0;
        #1;
        check("a_both_usage", 64'(a_usage), 64'(2));
        check("a_both_beats", 64'(a_beats), 64'(11));
        check("a_both_head", 64'(a_addr), 64'('h4000));

        // Drain in order.
        mr_a = 1'b1;
        tick();
        check("a_drain1_head", 64'(a_addr), 64'('h5000));
        check("a_drain1_len", 64'(a_len), 64'(7));
        check("a_drain1_usage", 64'(a_usage), 64'(1));
        check("a_drain1_beats", 64'(a_beats), 64'(8));
        tick();
        mr_a = 1'b0;
        check("a_drain2_usage", 64'(a_usage), 64'(0));
        check("a_drain2_beats", 64'(a_beats), 64'(0));
        check("a_drain2_valid", 64'(a_valid), 64'(0));

        // Fall-through on empty AR buffer; atop must read as zero.
        set_req(32'hABCD0000, 8'd5, 4'd9, 6'h2A);
        sv_b = 1'b1;
        mr_b = 1'b1;
        #1;
        check("b_ft_valid", 64'(b_valid), 64'(1));
        check("b_ft_addr", 64'(b_addr), 64'('hABCD0000));
        check("b_ft_len", 64'(b_len), 64'(5));
        check("b_ft_id", 64'(b_id), 64'(9));
        check("b_ft_atop", 64'(b_atop), 64'(0));
        tick();
        sv_b = 1'b0;
        mr_b = 1'b0;
        #1;
        check("b_ft_usage", 64'(b_usage), 64'(0));
        check("b_ft_beats", 64'(b_beats), 64'(0));
        check("b_ft_idle_valid", 64'(b_valid), 64'(0));

        // Stream 10 entries through DEPTH=3: fill 3 with downstream stalled, then pop every cycle.
        beats_m = 0;
        next_k  = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            cur_addr = (next_k + 1) * 256;
            cur_len  = (next_k + 1) % 4;
            set_req(32'(cur_addr), 8'(cur_len), 4'(next_k), 6'h2A);
            sv_b = (next_k < 10);
            mr_b = (cyc >= 3);
            #1;
            exp_valid = (q_addr.size() > 0) || sv_b;
            exp_ready = (q_addr.size() != 3);
            check("b_wrap_valid", 64'(b_valid), 64'(exp_valid));
            check("b_wrap_ready", 64'(b_ready), 64'(exp_ready));
            if (exp_valid) begin
                check("b_wrap_head", 64'(b_addr),
                      64'((q_addr.size() > 0) ? q_addr[0] : cur_addr));
                check("b_wrap_atop", 64'(b_atop), 64'(0));
            end
            push = sv_b && exp_ready;
            pop  = exp_valid && mr_b;
            if (!(q_addr.size() == 0 && push && pop)) begin
                if (pop) begin
                    beats_m -= q_len[0] + 1;
                    void'(q_addr.pop_front());
                    void'(q_len.pop_front());
                end
                if (push) begin
                    q_addr.push_back(cur_addr);
                    q_len.push_back(cur_len);
                    beats_m += cur_len + 1;
                end
            end
            if (push) next_k++;
            tick();
            check("b_wrap_usage", 64'(b_usage), 64'(q_addr.size()));
            check("b_wrap_beats", 64'(b_beats), 64'(beats_m));
        end
        sv_b = 1'b0;
        mr_b = 1'b0;
        check("b_wrap_all_sent", 64'(next_k), 64'(10));

        // Queue two requests in each instance, then reset asynchronously mid-stream.
        set_req(32'h7000, 8'd4, 4'd7, 6'h0);
        sv_a = 1'b1;
        sv_b = 1'b1;
        tick();
        set_req(32'h8000, 8'd1, 4'd8, 6'h0);
        tick();
        sv_a = 1'b0;
        sv_b = 1'b0;
        #1;
        check("pre_rst_a_usage", 64'(a_usage), 64'(2));
        check("pre_rst_b_usage", 64'(b_usage), 64'(2));
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_a_valid", 64'(a_valid), 64'(0));
        check("mid_rst_a_usage", 64'(a_usage), 64'(0));
        check("mid_rst_a_beats", 64'(a_beats), 64'(0));
        check("mid_rst_a_ready", 64'(a_ready), 64'(1));
        check("mid_rst_a_addr", 64'(a_addr), 64'(0));
        check("mid_rst_b_valid", 64'(b_valid), 64'(0));
        check("mid_rst_b_usage", 64'(b_usage), 64'(0));
        check("mid_rst_b_beats", 64'(b_beats), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_a_valid", 64'(a_valid), 64'(0));
        check("post_rst_b_usage", 64'(b_usage), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
